uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single 9600-baud UART transmitter between several message sources, such as prompt/reply string printers and a keystroke echo path. Each source presents one byte at a time with a `last` flag. The arbiter grants whole messages in round-robin order and steps bytes into the UART's `transmit`/`tx_byte` interface, pacing on `is_transmitting`. It sits between the application FSMs and the `uart` instance, replacing per-FSM muxing of `transmit`/`tx_byte`.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 1..4.
- `HOLD_TIMEOUT`, default 1_000_000: cycles an owner may keep `req` low mid-message before it loses the grant (10 ms at 100 MHz).
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: requester i has a valid byte on its slice.
- `req_byte` in NUM_REQ*8: requester i byte at `[i*8 +: 8]`.
- `req_last` in NUM_REQ: requester i's current byte ends its message.
- `ack` out NUM_REQ: one-cycle pulse; requester i's byte was taken and the next byte may be presented from the following cycle.
- `grant` out NUM_REQ: one-hot current owner; all zero when idle.
- `busy` out 1: high whenever state is not S_IDLE.
- `drop_err` out 1: one-cycle pulse when an owner is released by timeout.
- `transmit` out 1: to `uart.transmit`.
- `tx_byte` out 8: to `uart.tx_byte`.
- `is_transmitting` in 1: from `uart`.

## Operation
- All outputs are registered. Reset values: `ack`=0, `grant`=0, `busy`=0, `drop_err`=0, `transmit`=0, `tx_byte`=8'h00, state S_IDLE, `last_owner`=NUM_REQ-1 so that the first arbitration starts at index 0.
- S_IDLE
  - If any `req` is high, pick the first set index searching upward from `(last_owner+1) mod NUM_REQ`.
  - Register the pick into `grant` and go to S_START.
- S_START, with `req[owner]` high:
  - Load `tx_byte` with the owner's byte.
  - Pulse `transmit` and `ack[owner]`, each for exactly one cycle.
  - Latch `last_q` from `req_last[owner]`, clear the hold counter, and go to S_WAIT_BUSY.
- S_START, with `req[owner]` low:
  - Increment the hold counter.
  - When it reaches HOLD_TIMEOUT-1: pulse `drop_err`, set `last_owner` to owner, clear `grant`, and go to S_IDLE.
- S_WAIT_BUSY: wait for `is_transmitting`=1, then go to S_WAIT_DONE. There is no timeout in this state.
- S_WAIT_DONE: wait for `is_transmitting`=0.
  - If `last_q` is set: set `last_owner` to owner, clear `grant`, and go to S_IDLE.
  - Otherwise go back to S_START.
- Once granted, ownership holds until the owner's `last` byte has finished transmitting. No other requester can interleave bytes mid-message.
- A requester asserting `req` while another owns the grant waits. Its `ack` stays 0.
- Simultaneous requests in S_IDLE are resolved by the round-robin order only. There is no fixed priority.
- Single-byte messages (`req_last`=1 on the first byte) are legal.
- `req_byte` of 8'h00 is transmitted like any other byte. End of message is signalled only by `req_last`.
- Changes to `req`, `req_byte` or `req_last` in cycles other than S_START are ignored.
- Reset asserted mid-message: immediate return to reset values. The partially sent message is abandoned and nothing is replayed.

## Timing
- `req[i]` rises at edge 0 while S_IDLE:
  - `grant[i]`=1 after edge 1.
  - `transmit`, `ack[i]` and `tx_byte` are valid after edge 2.
  - `transmit` and `ack[i]` drop after edge 3.
- Minimum time from first request to `transmit` is 2 cycles.
- Byte-to-byte gap within a message: 1 cycle in S_WAIT_DONE→S_START, plus 1 cycle in S_START, after `is_transmitting` falls.
- After a `last` byte, a different requester's `transmit` comes at least 3 cycles after `is_transmitting` falls (S_IDLE→S_START→fire).
- `tx_byte` holds its value until the next `transmit`.

## Structure
- Package `uart_arb_pkg` holds:
  - the state encoding, 2 bits: S_IDLE=0, S_START=1, S_WAIT_BUSY=2, S_WAIT_DONE=3;
  - the hold-counter width, `$clog2(HOLD_TIMEOUT)+1`.
- Sub-module `uart_rr_pick` is purely combinational:
  - inputs: `req[NUM_REQ]` and `last_owner`;
  - outputs: one-hot `pick` and `any`.
- The top level contains the FSM, the hold counter, and the output registers.

## Test plan
- Reset, then requester 0 sends the 3-byte message "Hi\n" with `last` on 8'h0A; a behavioural UART holds `is_transmitting` for 10 cycles per byte.
  - Expect exactly 3 `transmit` pulses, with `tx_byte` = 8'h48, 8'h69, 8'h0A.
  - Expect 3 `ack[0]` pulses, `grant`=2'b01 throughout, and `grant`=0 and `busy`=0 afterwards.
- Requesters 0 and 1 raise `req` on the same cycle, each sending 2 bytes ("AB" and "cd").
  - Expect the UART sequence A, B, c, d with no interleaving.
  - Repeat the same collision: expect c, d, A, B (the round-robin pointer has advanced).
- Requester 1 requests while requester 0 is mid-message.
  - Expect `ack[1]`=0 until requester 0's `last` byte finishes.
  - Then expect `grant`=2'b10 and requester 1's `transmit` at least 3 cycles after `is_transmitting` falls.
- With HOLD_TIMEOUT=16, requester 0 sends byte 8'h31 without `last`, then drops `req`.
  - Expect `drop_err` exactly 16 cycles after entering S_START, with `grant`=0.
  - A pending requester 1 is then granted.
- Assert `rst` during S_WAIT_BUSY of the second byte.
  - Expect all outputs at reset values on the same cycle (asynchronous).
  - After release, expect a new request on requester 1 to be granted first.
- Single-byte echo: requester 1 sends 8'h0D with `last`=1.
  - Expect one `transmit` with `tx_byte`=8'h0D.
  - Expect a return to S_IDLE one cycle after `is_transmitting` falls.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents:
//   arb_state_e     - 2-bit arbiter FSM state encoding
//   idx_width()     - width of a requester index for a given requester count
//   hold_cnt_width() - width of the hold counter for a given timeout
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } arb_state_e;

  // A single requester still needs a 1-bit index signal.
  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // One spare bit so the counter can hold HOLD_TIMEOUT-1 for any timeout.
  function automatic int hold_cnt_width(input int hold_timeout);
    return $clog2(hold_timeout) + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i        - request vector, one bit per requester
//   last_owner_i - index of the requester served most recently
//   pick_o       - one-hot winner: first set request at or above
//                  last_owner_i+1, wrapping round to index 0
//   any_o        - at least one request is set
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [idx_width(NUM_REQ)-1:0] last_owner_i,
  output logic [NUM_REQ-1:0]            pick_o,
  output logic                          any_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_req;
  logic [NUM_REQ-1:0] cand;

  // Requests strictly above the last owner take precedence; if there are
  // none, the search wraps and the lowest set request wins.
  always_comb begin
    hi_mask = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      hi_mask[j] = (IDX_W'(j) > last_owner_i);
    end
  end

  assign hi_req = req_i & hi_mask;
  assign cand   = (|hi_req) ? hi_req : req_i;
  // Isolate the lowest set bit.
  assign pick_o = cand & (~cand + NUM_REQ'(1));
  assign any_o  = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ message sources. Whole
// messages are granted in round-robin order; bytes are stepped into the
// UART's transmit/tx_byte interface, pacing on is_transmitting.
//
// Handshake: a requester holds req_i[i] high with req_byte_i/req_last_i
// stable until ack_o[i] pulses; the byte was taken on that pulse and the
// next byte may be presented from the following cycle. Request inputs are
// only looked at while the FSM is in S_START (and S_IDLE for arbitration).
//
// Ports:
//   clk_i, rst_i       - clock, asynchronous active-high reset
//   req_i              - per-requester byte valid
//   req_byte_i         - requester i byte at [i*8 +: 8]
//   req_last_i         - per-requester end-of-message flag
//   ack_o              - one-cycle byte-taken pulse
//   grant_o            - one-hot current owner, zero when idle
//   busy_o             - FSM is not in S_IDLE
//   drop_err_o         - one-cycle pulse when an owner is released by timeout
//   transmit_o         - start pulse to the UART
//   tx_byte_o          - byte to the UART, held until the next transmit
//   is_transmitting_i  - UART busy flag
//   state_o            - current FSM state (debug)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] req_byte_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 drop_err_o,
  output logic                 transmit_o,
  output logic [7:0]           tx_byte_o,
  input  logic                 is_transmitting_i,
  output arb_state_e           state_o
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int HCW   = hold_cnt_width(HOLD_TIMEOUT);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic               last_q, last_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               transmit_q, transmit_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               drop_q, drop_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick;
  logic               any_req;

  logic               own_req;
  logic               own_last;
  logic [7:0]         own_byte;
  logic [IDX_W-1:0]   own_idx;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i        (req_i),
    .last_owner_i (last_owner_q),
    .pick_o       (pick),
    .any_o        (any_req)
  );

  // Select the owner's request lane from the one-hot grant.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_byte = 8'h00;
    own_idx  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_q[j]) begin
        own_req  = req_i[j];
        own_last = req_last_i[j];
        own_byte = req_byte_i[j*8 +: 8];
        own_idx  = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    last_d       = last_q;
    hold_d       = hold_q;
    ack_d        = '0;
    transmit_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    drop_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          hold_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (own_req) begin
          tx_byte_d  = own_byte;
          transmit_d = 1'b1;
          ack_d      = grant_q;
          last_d     = own_last;
          hold_d     = '0;
          state_d    = S_WAIT_BUSY;
        end else if (hold_q == HOLD_LAST) begin
          // Owner stalled mid-message for too long: release it.
          drop_d       = 1'b1;
          last_owner_d = own_idx;
          grant_d      = '0;
          hold_d       = '0;
          state_d      = S_IDLE;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end

      S_WAIT_BUSY: begin
        if (is_transmitting_i) begin
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (!is_transmitting_i) begin
          if (last_q) begin
            last_owner_d = own_idx;
            grant_d      = '0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_START;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      last_q       <= 1'b0;
      hold_q       <= '0;
      ack_q        <= '0;
      transmit_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      ack_q        <= ack_d;
      transmit_q   <= transmit_d;
      tx_byte_q    <= tx_byte_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end

  assign ack_o      = ack_q;
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign drop_err_o = drop_q;
  assign transmit_o = transmit_q;
  assign tx_byte_o  = tx_byte_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with two requesters and a short hold timeout.
// A behavioural UART holds is_transmitting for 10 cycles per byte and
// checks every byte against an expected queue built from message-level
// round-robin ordering.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_i;
  logic [15:0] req_byte_i;
  logic [1:0]  req_last_i;
  logic [1:0]  ack_o;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic        drop_err_o;
  logic        transmit_o;
  logic [7:0]  tx_byte_o;
  logic        is_tx;
  arb_state_e  state_mon;

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .HOLD_TIMEOUT (16)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_i             (req_i),
    .req_byte_i        (req_byte_i),
    .req_last_i        (req_last_i),
    .ack_o             (ack_o),
    .grant_o           (grant_o),
    .busy_o            (busy_o),
    .drop_err_o        (drop_err_o),
    .transmit_o        (transmit_o),
    .tx_byte_o         (tx_byte_o),
    .is_transmitting_i (is_tx),
    .state_o           (state_mon)
  );

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];          // bytes the UART must see, in order
  logic [8:0] src0_q[$];         // {last, byte} still to be offered
  logic [8:0] src1_q[$];
  logic [7:0] m0[$];             // message under construction
  logic [7:0] m1[$];
  int         gap_log[$];        // negedges from previous fall to each transmit
  int         model_last = 1;    // last served requester (reference model)

  int tx_cnt = 0, ack_cnt0 = 0, ack_cnt1 = 0;
  int neg_cyc = 0, fall_neg = 0, uart_cnt = 0;
  logic       watch_grant = 1'b0;
  logic [1:0] watch_val   = 2'b00;
  int         grant_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural UART + scoreboard ----------------
  always @(negedge clk) begin
    neg_cyc++;
    if (rst) begin
      is_tx    = 1'b0;
      uart_cnt = 0;
    end else begin
      check("ack_with_transmit", 32'(ack_o), transmit_o ? 32'(grant_o) : 32'd0);
      check("grant_onehot0", 32'($countones(grant_o) <= 1), 32'd1);
      if (ack_o[0]) ack_cnt0++;
      if (ack_o[1]) ack_cnt1++;
      if (watch_grant && busy_o && grant_o != watch_val) grant_bad++;
      if (transmit_o) begin
        tx_cnt++;
        gap_log.push_back(neg_cyc - fall_neg);
        n_chk++;
        assert (!is_tx) else begin
          n_fail++;
          $error("FAIL transmit_while_busy: transmit=1 with is_transmitting=1, required is_transmitting=0");
        end
        n_chk++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_transmit: byte %02h sent, required no transmit", tx_byte_o);
        end
        if (exp_q.size() != 0) check("uart_byte", 32'(tx_byte_o), 32'(exp_q.pop_front()));
        is_tx    = 1'b1;
        uart_cnt = 10;
      end else if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          is_tx    = 1'b0;
          fall_neg = neg_cyc;
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  always @(negedge clk) begin
    if (ack_o[0] && src0_q.size() != 0) void'(src0_q.pop_front());
    if (ack_o[1] && src1_q.size() != 0) void'(src1_q.pop_front());
    if (src0_q.size() != 0) begin
      req_i[0] = 1'b1; req_byte_i[7:0] = src0_q[0][7:0]; req_last_i[0] = src0_q[0][8];
    end else begin
      req_i[0] = 1'b0; req_byte_i[7:0] = 8'($urandom); req_last_i[0] = 1'($urandom);
    end
    if (src1_q.size() != 0) begin
      req_i[1] = 1'b1; req_byte_i[15:8] = src1_q[0][7:0]; req_last_i[1] = src1_q[0][8];
    end else begin
      req_i[1] = 1'b0; req_byte_i[15:8] = 8'($urandom); req_last_i[1] = 1'($urandom);
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic int rr_first(input logic [1:0] mask, input int last);
    for (int k = 1; k <= 2; k++) begin
      int idx;
      idx = (last + k) % 2;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic enqueue(input int r);
    logic lst;
    if (r == 0) begin
      for (int i = 0; i < m0.size(); i++) begin
        lst = (i == m0.size() - 1);
        exp_q.push_back(m0[i]);
        src0_q.push_back({lst, m0[i]});
      end
      m0.delete();
    end else begin
      for (int i = 0; i < m1.size(); i++) begin
        lst = (i == m1.size() - 1);
        exp_q.push_back(m1[i]);
        src1_q.push_back({lst, m1[i]});
      end
      m1.delete();
    end
  endtask

  // Offer the prepared messages of the requesters in mask at the same time.
  task automatic launch(input logic [1:0] mask);
    int first;
    first = rr_first(mask, model_last);
    enqueue(first);
    model_last = first;
    if (mask == 2'b11) begin
      enqueue(1 - first);
      model_last = 1 - first;
    end
  endtask

  task automatic rand_msg(input int r, input int len);
    for (int i = 0; i < len; i++) begin
      if (r == 0) m0.push_back(8'($urandom_range(0, 255)));
      else        m1.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && src0_q.size() == 0 && src1_q.size() == 0 &&
             !is_tx && busy_o == 1'b0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    assert (n < 3000) else begin
      n_fail++;
      $error("FAIL %s_idle_timeout: waited %0d cycles, required under 3000", tag, n);
    end
  endtask

  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!is_tx && n < 100);
    while (is_tx && n < 200) begin @(negedge clk); #1; n++; end
    n_chk++;
    assert (n < 200) else begin
      n_fail++;
      $error("FAIL %s_fall_timeout: waited %0d cycles, required under 200", tag, n);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},      32'(ack_o),      32'd0);
    check({tag, "_grant"},    32'(grant_o),    32'd0);
    check({tag, "_busy"},     32'(busy_o),     32'd0);
    check({tag, "_drop"},     32'(drop_err_o), 32'd0);
    check({tag, "_transmit"}, 32'(transmit_o), 32'd0);
    check({tag, "_tx_byte"},  32'(tx_byte_o),  32'd0);
    check({tag, "_state"},    32'(state_mon),  32'(S_IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, base, ack1_seen, early;
    rst = 1'b1;
    req_i = '0; req_byte_i = '0; req_last_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // "Hi\n" from requester 0, with first-request timing.
    @(posedge clk); #1;
    m0.push_back(8'h48); m0.push_back(8'h69); m0.push_back(8'h0A);
    gap_log.delete();
    base = tx_cnt; n = ack_cnt0;
    watch_val = 2'b01; watch_grant = 1'b1;
    launch(2'b01);
    @(posedge clk); #1;
    check("hi_grant_edge1", 32'(grant_o), 32'h1);
    check("hi_tx_edge1", 32'(transmit_o), 32'd0);
    @(posedge clk); #1;
    check("hi_tx_edge2", 32'(transmit_o), 32'd1);
    check("hi_ack_edge2", 32'(ack_o), 32'h1);
    check("hi_byte_edge2", 32'(tx_byte_o), 32'h48);
    @(posedge clk); #1;
    check("hi_tx_edge3", 32'(transmit_o), 32'd0);
    check("hi_ack_edge3", 32'(ack_o), 32'd0);
    wait_idle("hi");
    watch_grant = 1'b0;
    check("hi_tx_count", 32'(tx_cnt - base), 32'd3);
    check("hi_ack0_count", 32'(ack_cnt0 - n), 32'd3);
    check("hi_grant_held", 32'(grant_bad), 32'd0);
    check("hi_grant_after", 32'(grant_o), 32'd0);
    check("hi_busy_after", 32'(busy_o), 32'd0);
    check("hi_gap_count", 32'(gap_log.size()), 32'd3);
    if (gap_log.size() == 3) begin
      check("hi_gap1", 32'(gap_log[1]), 32'd2);
      check("hi_gap2", 32'(gap_log[2]), 32'd2);
    end

    // Two collisions of "AB" and "cd".
    for (int rep = 0; rep < 2; rep++) begin
      @(posedge clk); #1;
      m0.push_back(8'h41); m0.push_back(8'h42);
      m1.push_back(8'h63); m1.push_back(8'h64);
      launch(2'b11);
      wait_idle("collide");
    end

    // Requester 1 arrives while requester 0 is mid-message.
    @(posedge clk); #1;
    gap_log.delete();
    base = tx_cnt;
    rand_msg(0, 3);
    launch(2'b01);
    n = 0;
    while (!ack_o[0] && n < 200) begin @(posedge clk); #1; n++; end
    rand_msg(1, 2);
    launch(2'b10);
    ack1_seen = 0; n = 0;
    while (grant_o != 2'b10 && n < 500) begin
      @(posedge clk); #1; n++;
      if (ack_o[1] && grant_o != 2'b10) ack1_seen++;
    end
    check("mid_grant_moves", 32'(grant_o), 32'h2);
    check("mid_ack1_blocked", 32'(ack1_seen), 32'd0);
    check("mid_r0_done_first", 32'(tx_cnt - base), 32'd3);
    wait_idle("mid");
    check("mid_gap_count", 32'(gap_log.size()), 32'd5);
    if (gap_log.size() == 5) check("mid_handover_gap_ge3", 32'(gap_log[3] >= 3), 32'd1);

    // Hold timeout: requester 0 offers one byte without last, then goes quiet.
    @(posedge clk); #1;
    src0_q.push_back({1'b0, 8'h31});
    exp_q.push_back(8'h31);
    model_last = 0;
    n = 0;
    while (!transmit_o && n < 200) begin @(posedge clk); #1; n++; end
    check("drop_tx31_seen", 32'(transmit_o), 32'd1);
    rand_msg(1, 2);
    launch(2'b10);
    wait_fall("drop");
    early = 0;
    for (int i = 0; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i < 16 && drop_err_o) early++;
      if (i == 16) begin
        check("drop_pulse", 32'(drop_err_o), 32'd1);
        check("drop_grant_clear", 32'(grant_o), 32'd0);
      end
      if (i == 17) begin
        check("drop_one_cycle", 32'(drop_err_o), 32'd0);
        check("drop_next_grant", 32'(grant_o), 32'h2);
      end
    end
    check("drop_not_early", 32'(early), 32'd0);
    wait_idle("drop");

    // Reset during S_WAIT_BUSY of the second byte.
    @(posedge clk); #1;
    rand_msg(0, 3);
    launch(2'b01);
    n = 0; base = 0;
    while (base < 2 && n < 300) begin
      @(posedge clk); #1; n++;
      if (transmit_o) base++;
    end
    check("rst_second_tx_seen", 32'(base), 32'd2);
    check("rst_in_wait_busy", 32'(state_mon), 32'(S_WAIT_BUSY));
    #1;
    rst = 1'b1;
    src0_q.delete(); src1_q.delete(); exp_q.delete();
    model_last = 1;
    #1;
    check_reset_values("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rand_msg(1, 2);
    launch(2'b10);
    @(posedge clk); #1;
    check("rst_r1_granted", 32'(grant_o), 32'h2);
    wait_idle("rst");

    // Single-byte echo.
    @(posedge clk); #1;
    base = tx_cnt;
    m1.push_back(8'h0D);
    launch(2'b10);
    wait_fall("echo");
    check("echo_busy_at_fall", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    check("echo_idle_after_fall", 32'(state_mon), 32'(S_IDLE));
    check("echo_busy_clear", 32'(busy_o), 32'd0);
    check("echo_tx_count", 32'(tx_cnt - base), 32'd1);
    wait_idle("echo");

    // Random traffic.
    for (int r = 0; r < 8; r++) begin
      logic [1:0] mask;
      @(posedge clk); #1;
      mask = 2'($urandom_range(1, 3));
      if (mask[0]) rand_msg(0, $urandom_range(1, 4));
      if (mask[1]) rand_msg(1, $urandom_range(1, 4));
      launch(mask);
      wait_idle("random");
    end
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
